// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
//
// Selects which test pattern a downstream pattern generator displays.
// Pattern changes are only ever applied at a frame boundary (rising edge of
// vertical blank) so the picture never tears mid-frame.
//
// Two modes:
//   MANUAL - the pattern only moves on user next/prev requests.
//   AUTO   - the pattern advances by one every FRAMES_PER_PATTERN frames.
//            User requests still take effect and restart the frame count.
//
// User requests are remembered in a one-deep "pending" register. The most
// recent request wins. The request is applied at the next frame boundary.
//
// Ports
//   i_clk          pixel clock; all state changes on its rising edge
//   i_rst_n        synchronous active-low reset
//   i_vblank       vertical blank flag from the timing generator
//   i_next         one-cycle request to step the pattern forward
//   i_prev         one-cycle request to step the pattern back
//   i_auto_toggle  one-cycle request to flip between MANUAL and AUTO
//   o_pattern_sel  registered pattern index (0 .. NUM_PATTERNS-1)
//   o_auto         high while in AUTO mode (the mode FSM state)
//   o_frame_tick   one-cycle pulse, high in the cycle after the vblank rise
//   o_pending      high while a manual request waits for a frame boundary
// ---------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int unsigned NUM_PATTERNS       = 8,   // 2..8
    parameter int unsigned FRAMES_PER_PATTERN = 120  // 1..1023
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vblank,
    input  logic       i_next,
    input  logic       i_prev,
    input  logic       i_auto_toggle,
    output logic [2:0] o_pattern_sel,
    output logic       o_auto,
    output logic       o_frame_tick,
    output logic       o_pending
);

    localparam logic [2:0] LAST_PAT   = 3'(NUM_PATTERNS - 1);
    localparam logic [9:0] LAST_FRAME = 10'(FRAMES_PER_PATTERN - 1);

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_NEXT = 2'd1,
        PEND_PREV = 2'd2
    } pend_e;

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    mode_e      mode_q,     mode_d;
    pend_e      pend_q,     pend_d;
    logic [2:0] pat_q,      pat_d;
    logic [9:0] cnt_q,      cnt_d;
    logic       vblank_q,   vblank_d;
    logic       tick_q,     tick_d;

    // -----------------------------------------------------------------------
    // Helper terms
    // -----------------------------------------------------------------------
    logic       boundary;
    logic       req_next;
    logic       req_prev;
    logic [2:0] pat_inc;
    logic [2:0] pat_dec;

    // vblank_q resets high, so a vblank that is already high when reset
    // releases is not mistaken for a rising edge.
    assign boundary = i_vblank & ~vblank_q;

    // Simultaneous next and prev cancel out and leave pending untouched.
    assign req_next = i_next & ~i_prev;
    assign req_prev = i_prev & ~i_next;

    // Wrapping step in both directions over 0 .. NUM_PATTERNS-1.
    assign pat_inc = (pat_q == LAST_PAT) ? 3'd0     : pat_q + 3'd1;
    assign pat_dec = (pat_q == 3'd0)     ? LAST_PAT : pat_q - 3'd1;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        mode_d   = mode_q;
        pend_d   = pend_q;
        pat_d    = pat_q;
        cnt_d    = cnt_q;
        vblank_d = i_vblank;
        tick_d   = boundary;

        if (boundary) begin
            unique case (pend_q)
                PEND_NEXT: begin
                    pat_d = pat_inc;
                    cnt_d = 10'd0;
                end
                PEND_PREV: begin
                    pat_d = pat_dec;
                    cnt_d = 10'd0;
                end
                default: begin
                    // No manual request: only AUTO mode counts frames.
                    // MANUAL leaves the counter at 0.
                    if (mode_q == MODE_AUTO) begin
                        if (cnt_q == LAST_FRAME) begin
                            cnt_d = 10'd0;
                            pat_d = pat_inc;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                end
            endcase
            pend_d = PEND_NONE;
        end

        // A request sampled in the boundary cycle overrides the clear above,
        // so it survives and is applied at the following boundary.
        if (req_next) begin
            pend_d = PEND_NEXT;
        end else if (req_prev) begin
            pend_d = PEND_PREV;
        end

        // Mode change always restarts the frame count from zero.
        if (i_auto_toggle) begin
            mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
            cnt_d  = 10'd0;
        end
    end

    // -----------------------------------------------------------------------
    // Registers: mode FSM, pending request, pattern, frame counter, edge
    // detector and frame tick, all with synchronous active-low reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q   <= MODE_MANUAL;
            pend_q   <= PEND_NONE;
            pat_q    <= 3'd0;
            cnt_q    <= 10'd0;
            vblank_q <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            pat_q    <= pat_d;
            cnt_q    <= cnt_d;
            vblank_q <= vblank_d;
            tick_q   <= tick_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from registers)
    // -----------------------------------------------------------------------
    assign o_pattern_sel = pat_q;
    assign o_auto        = (mode_q == MODE_AUTO);
    assign o_frame_tick  = tick_q;
    assign o_pending     = (pend_q != PEND_NONE);

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
//
// Self-checking bench for pattern_sequencer with NUM_PATTERNS=5 and
// FRAMES_PER_PATTERN=3. Inputs are driven on the falling edge, a behavioural
// model is advanced on the rising edge with the same inputs, and the DUT
// outputs are compared against it on the next falling edge. Directed
// scenarios add checks against fixed expected values; a randomized phase
// follows.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;

  localparam int NP = 5;
  localparam int FP = 3;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vblank;
  logic       next_req;
  logic       prev_req;
  logic       auto_toggle;
  logic [2:0] pattern_sel;
  logic       auto_mode;
  logic       frame_tick;
  logic       pending;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NUM_PATTERNS       (NP),
    .FRAMES_PER_PATTERN (FP)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_vblank      (vblank),
    .i_next        (next_req),
    .i_prev        (prev_req),
    .i_auto_toggle (auto_toggle),
    .o_pattern_sel (pattern_sel),
    .o_auto        (auto_mode),
    .o_frame_tick  (frame_tick),
    .o_pending     (pending)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and the checking task
  // -------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: pattern as an integer index, the last request as a
  // word (0 none, 1 next, 2 prev), and a count of frames since the pattern
  // last changed in auto mode.
  // -------------------------------------------------------------------------
  int m_pat;
  int m_auto;
  int m_req;
  int m_frames;
  int m_vb_prev;
  int m_tick;

  task automatic model_step(input bit r, input bit vb, input bit nx, input bit pv, input bit tg);
    bit edge_seen;
    if (!r) begin
      m_pat = 0; m_auto = 0; m_req = 0; m_frames = 0; m_vb_prev = 1; m_tick = 0;
      return;
    end
    edge_seen = vb && (m_vb_prev == 0);
    m_tick    = edge_seen;
    if (edge_seen) begin
      if (m_req == 1) begin
        m_pat = (m_pat + 1) % NP;
        m_frames = 0;
      end else if (m_req == 2) begin
        m_pat = (m_pat + NP - 1) % NP;
        m_frames = 0;
      end else if (m_auto != 0) begin
        m_frames = m_frames + 1;
        if (m_frames == FP) begin
          m_frames = 0;
          m_pat = (m_pat + 1) % NP;
        end
      end
      m_req = 0;
    end
    if (nx && !pv) m_req = 1;
    else if (pv && !nx) m_req = 2;
    if (tg) begin
      m_auto = (m_auto != 0) ? 0 : 1;
      m_frames = 0;
    end
    m_vb_prev = vb;
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic drive_cycle(input bit r, input bit vb, input bit nx, input bit pv, input bit tg);
    rst_n       = r;
    vblank      = vb;
    next_req    = nx;
    prev_req    = pv;
    auto_toggle = tg;
    @(posedge clk);
    model_step(r, vb, nx, pv, tg);
    @(negedge clk);
    check_eq("pattern_sel", pattern_sel, m_pat);
    check_eq("auto",        auto_mode,   m_auto);
    check_eq("frame_tick",  frame_tick,  m_tick);
    check_eq("pending",     pending,     (m_req != 0) ? 1 : 0);
  endtask

  task automatic do_reset(input bit vb);
    drive_cycle(1'b0, vb, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, vb, 1'b0, 1'b0, 1'b0);
  endtask

  // One low cycle then the vblank rise; on return the tick is visible.
  task automatic frame_edge();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0; vblank = 1'b0; next_req = 1'b0; prev_req = 1'b0; auto_toggle = 1'b0;
    m_pat = 0; m_auto = 0; m_req = 0; m_frames = 0; m_vb_prev = 1; m_tick = 0;
    @(negedge clk);

    // Reset state
    do_reset(1'b0);
    check_eq("rst_pattern", pattern_sel, 0);
    check_eq("rst_auto",    auto_mode,   0);
    check_eq("rst_tick",    frame_tick,  0);
    check_eq("rst_pending", pending,     0);

    // Next request mid-frame waits for the vblank rise
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("next_pending", pending, 1);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("next_hold_pat", pattern_sel, 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("next_tick",    frame_tick,  1);
    check_eq("next_pat",     pattern_sel, 1);
    check_eq("next_cleared", pending,     0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("tick_one_cycle", frame_tick, 0);

    // Wrap both ways
    do_reset(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_edge();
    check_eq("wrap_prev", pattern_sel, 4);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frame_edge();
    check_eq("wrap_next", pattern_sel, 0);

    // Auto mode: advance every third frame
    do_reset(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("auto_on", auto_mode, 1);
    for (int f = 1; f <= 7; f++) begin
      frame_edge();
      check_eq($sformatf("auto_f%0d", f), pattern_sel, f / 3);
    end

    // Auto mode: latest request wins, frame count restarts
    do_reset(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    frame_edge();                       // one auto frame counted
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_edge();
    check_eq("latest_prev", pattern_sel, 4);
    frame_edge();
    frame_edge();
    check_eq("restart_hold", pattern_sel, 4);
    frame_edge();
    check_eq("restart_adv", pattern_sel, 0);

    // Simultaneous next/prev ignored; request in sample cycle deferred
    do_reset(1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("both_ignored", pending, 0);
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("late_tick",    frame_tick,  1);
    check_eq("late_unchg",   pattern_sel, 0);
    check_eq("late_pending", pending,     1);
    frame_edge();
    check_eq("late_applied", pattern_sel, 1);

    // Reset with a request pending discards it
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_discard_pend", pending, 0);
    check_eq("rst_discard_pat",  pattern_sel, 0);

    // vblank high through reset release: no spurious tick
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("vb_high_notick", frame_tick, 0);
    end
    frame_edge();
    check_eq("vb_rise_tick", frame_tick, 1);

    // Randomized frames
    do_reset(1'b0);
    for (int f = 0; f < 60; f++) begin
      int act_len;
      int blk_len;
      act_len = $urandom_range(2, 8);
      blk_len = $urandom_range(1, 3);
      for (int c = 0; c < act_len + blk_len; c++) begin
        bit r, nx, pv, tg;
        r  = ($urandom_range(0, 249) != 0);
        nx = ($urandom_range(0, 7) == 0);
        pv = ($urandom_range(0, 7) == 0);
        tg = ($urandom_range(0, 39) == 0);
        drive_cycle(r, (c >= act_len), nx, pv, tg);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
